// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter/mux.
package bus_pkg;
    typedef enum logic {
        M0_GRANT = 1'b0,
        M1_GRANT = 1'b1
    } arb_state_e;

    localparam int MAX_HOLD_DEF = 16;
endpackage

// File: rtl/bus_arb_fsm.sv
// Two-state grant FSM; optional fairness hold counter enabled by BUS_ARB_HOLD_EN.
module bus_arb_fsm
    import bus_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic m0_req_i,
    input  logic m1_req_i,
    output logic m0_grant_o,
    output logic m1_grant_o
);
    arb_state_e state_q, state_d;
    logic       hold_expire;

`ifdef BUS_ARB_HOLD_EN
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          both_req;

    assign both_req    = m0_req_i & m1_req_i;
    assign hold_expire = both_req && (cnt_q == CW'(MAX_HOLD - 1));

    // Clears on a grant change or as soon as contention goes away.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!both_req || (state_d != state_q))
            cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`else
    assign hold_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= M0_GRANT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            M0_GRANT: if ((!m0_req_i && m1_req_i) || hold_expire) state_d = M1_GRANT;
            M1_GRANT: if (!m1_req_i || hold_expire)               state_d = M0_GRANT;
            default:  state_d = M0_GRANT;
        endcase
    end

    always_comb begin
        m0_grant_o = (state_q == M0_GRANT);
        m1_grant_o = (state_q == M1_GRANT);
    end
endmodule

// File: rtl/bus_arbit_mux.sv
// Two-master bus: grant FSM, grant-steered request mux, registered read-return select.
// Optional hold-limit fairness: define BUS_ARB_HOLD_EN.
module bus_arbit_mux
    import bus_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_wr,
    input  logic        m1_wr,
    input  logic [7:0]  m0_address,
    input  logic [7:0]  m1_address,
    input  logic [31:0] m0_dout,
    input  logic [31:0] m1_dout,
    input  logic        s0_sel,
    input  logic        s1_sel,
    input  logic [31:0] s0_dout,
    input  logic [31:0] s1_dout,
    output logic        m0_grant,
    output logic        m1_grant,
    output logic        s_req,
    output logic        s_wr,
    output logic [7:0]  s_address,
    output logic [31:0] s_din,
    output logic [31:0] m_din
);
    logic [1:0] rd_sel_q, rd_sel_d;

    bus_arb_fsm #(.MAX_HOLD(MAX_HOLD)) u_fsm (
        .clk        (clk),
        .reset_n    (reset_n),
        .m0_req_i   (m0_req),
        .m1_req_i   (m1_req),
        .m0_grant_o (m0_grant),
        .m1_grant_o (m1_grant)
    );

    always_comb begin
        if (m1_grant) begin
            s_req     = m1_req;
            s_wr      = m1_req & m1_wr;
            s_address = m1_address;
            s_din     = m1_dout;
        end else begin
            s_req     = m0_req;
            s_wr      = m0_req & m0_wr;
            s_address = m0_address;
            s_din     = m0_dout;
        end
    end

    // Return path keys off the select captured with the read, not the live grant.
    assign rd_sel_d = (s_req && !s_wr) ? {s1_sel, s0_sel} : 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_sel_q <= 2'b00;
        else          rd_sel_q <= rd_sel_d;
    end

    always_comb begin
        m_din = 32'h0;
        if (rd_sel_q[0])      m_din = s0_dout;
        else if (rd_sel_q[1]) m_din = s1_dout;
    end
endmodule
